// File: rtl/ysyx_22040088_multicycle_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the NPC core: owns PC, IR and the memory handshakes.
// Optional build macro CTRL_PERF_EN adds free-running perf_cycles / perf_retired counters.
module ysyx_22040088_multicycle_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = 'h8000_0000,
  parameter int              TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     inst,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_is_ebreak,
  input  logic [XLEN-1:0] exu_nextpc,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_wen,
  input  logic            dmem_resp_valid,
  output logic            rf_wen,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            timeout_err
`ifdef CTRL_PERF_EN
  ,
  output logic [63:0]     perf_cycles,
  output logic [63:0]     perf_retired
`endif
);

  typedef enum logic [2:0] {
    S_IF_REQ,
    S_IF_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT,
    S_ERR
  } state_e;

  // The counter trips when it would reach all-ones, i.e. after 2**TIMEOUT_W-1 wait cycles.
  localparam logic [TIMEOUT_W-1:0] CNT_TRIP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                state_q;
  logic [XLEN-1:0]       pc_q;
  logic [31:0]           inst_q;
  logic                  store_q;
  logic                  halted_q;
  logic                  tmo_q;
  logic [TIMEOUT_W-1:0]  cnt_q;
  logic [TIMEOUT_W-1:0]  cnt_d;
  logic                  tmo_hit;

  always_comb begin
    cnt_d   = cnt_q + TIMEOUT_W'(1);
    tmo_hit = (cnt_q >= CNT_TRIP);
  end

  // Strobes decode only registered state, so no input reaches an output combinationally.
  assign imem_req_valid = (state_q == S_IF_REQ);
  assign imem_req_addr  = pc_q;
  assign dmem_req_valid = (state_q == S_MEM_REQ);
  assign dmem_req_wen   = dmem_req_valid & store_q;
  assign rf_wen         = (state_q == S_WB) & ~store_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign timeout_err    = tmo_q;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values of state_q/cnt_q regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IF_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0000_0013;
      store_q  <= 1'b0;
      halted_q <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IF_REQ: begin
          cnt_q <= cnt_d;
          if (imem_req_ready) begin
            state_q <= S_IF_WAIT;
          end else if (tmo_hit) begin
            state_q <= S_ERR;
            tmo_q   <= 1'b1;
          end
        end
        S_IF_WAIT: begin
          cnt_q <= cnt_d;
          if (imem_resp_valid) begin
            inst_q  <= imem_resp_data;
            state_q <= S_EXEC;
          end else if (tmo_hit) begin
            state_q <= S_ERR;
            tmo_q   <= 1'b1;
          end
        end
        S_EXEC: begin
          store_q <= dec_is_store;
          if (dec_is_ebreak) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (dec_is_load | dec_is_store) begin
            state_q <= S_MEM_REQ;
            cnt_q   <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM_REQ: begin
          cnt_q <= cnt_d;
          if (dmem_req_ready) begin
            state_q <= S_MEM_WAIT;
          end else if (tmo_hit) begin
            state_q <= S_ERR;
            tmo_q   <= 1'b1;
          end
        end
        S_MEM_WAIT: begin
          cnt_q <= cnt_d;
          if (dmem_resp_valid) begin
            state_q <= S_WB;
          end else if (tmo_hit) begin
            state_q <= S_ERR;
            tmo_q   <= 1'b1;
          end
        end
        S_WB: begin
          pc_q    <= exu_nextpc;
          cnt_q   <= '0;
          state_q <= S_IF_REQ;
        end
        S_HALT:  state_q <= S_HALT;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  // An ebreak retires on its EXEC->HALT transition; normal instructions retire in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles  <= 64'd0;
      perf_retired <= 64'd0;
    end else begin
      if (state_q != S_HALT && state_q != S_ERR) begin
        perf_cycles <= perf_cycles + 64'd1;
      end
      if (state_q == S_WB || (state_q == S_EXEC && dec_is_ebreak)) begin
        perf_retired <= perf_retired + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040088_multicycle_ctrl.sv
// Directed testbench for ysyx_22040088_multicycle_ctrl; the bench plays memory, IDU and EXU cycle by cycle.
// Perf counter scenario is compiled only when CTRL_PERF_EN is defined.
module tb_ysyx_22040088_multicycle_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_resp_data, inst;
  logic        dec_is_load, dec_is_store, dec_is_ebreak;
  logic [63:0] exu_nextpc, pc;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_wen, dmem_resp_valid;
  logic        rf_wen, halted, timeout_err;
`ifdef CTRL_PERF_EN
  logic [63:0] perf_cycles, perf_retired;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22040088_multicycle_ctrl #(
    .XLEN(64), .RESET_PC(64'h8000_0000), .TIMEOUT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .exu_nextpc(exu_nextpc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_wen(dmem_req_wen), .dmem_resp_valid(dmem_resp_valid),
    .rf_wen(rf_wen), .pc(pc), .halted(halted), .timeout_err(timeout_err)
`ifdef CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    dec_is_load     = 1'b0;
    dec_is_store    = 1'b0;
    dec_is_ebreak   = 1'b0;
    exu_nextpc      = 64'h0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Zero-wait fetch: call in IF_REQ, returns one sample point into EXEC.
  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  task automatic run_alu(input logic [31:0] data, input logic [63:0] nextpc);
    dec_is_load   = 1'b0;
    dec_is_store  = 1'b0;
    dec_is_ebreak = 1'b0;
    exu_nextpc    = nextpc;
    do_fetch(data);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    n_vec++;
    if (pc !== RST_PC || inst !== NOP) begin
      n_err++; $display("FAIL reset_regs: pc=%h inst=%h want pc=%h inst=%h", pc, inst, RST_PC, NOP);
    end
    n_vec++;
    if ({rf_wen, dmem_req_valid, halted, timeout_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes: {rf_wen,dreq,halted,tmo}=%b want 0000",
                        {rf_wen, dmem_req_valid, halted, timeout_err});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_err++; $display("FAIL reset_first_req: valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    // One instruction, then reset in the middle of the next fetch wait.
    run_alu(32'h0050_0093, 64'h8000_0004);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_vec++;
    if (imem_req_valid !== 1'b0 || pc !== 64'h8000_0004 || inst !== 32'h0050_0093) begin
      n_err++; $display("FAIL pre_reset_if_wait: valid=%b pc=%h inst=%h want 0 80000004 00500093",
                        imem_req_valid, pc, inst);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (pc !== RST_PC || inst !== NOP) begin
      n_err++; $display("FAIL async_reset: pc=%h inst=%h want %h %h", pc, inst, RST_PC, NOP);
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst !== NOP) begin
      n_err++; $display("FAIL post_reset_req: valid=%b addr=%h inst=%h want 1 %h %h",
                        imem_req_valid, imem_req_addr, inst, RST_PC, NOP);
    end
  endtask

  task automatic test_alu_stream();
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0;
    exu_nextpc = 64'h8000_0004;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    n_vec++;
    if (imem_req_valid !== 1'b0 || rf_wen !== 1'b0) begin
      n_err++; $display("FAIL alu_cycle2: ireq=%b rf_wen=%b want 0 0", imem_req_valid, rf_wen);
    end
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if (inst !== 32'h0050_0093 || rf_wen !== 1'b0) begin
      n_err++; $display("FAIL alu_exec: inst=%h rf_wen=%b want 00500093 0", inst, rf_wen);
    end
    tick();
    n_vec++;
    if (rf_wen !== 1'b1 || pc !== RST_PC) begin
      n_err++; $display("FAIL alu_wb_cycle4: rf_wen=%b pc=%h want 1 %h", rf_wen, pc, RST_PC);
    end
    tick();
    n_vec++;
    if (rf_wen !== 1'b0 || pc !== 64'h8000_0004 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin
      n_err++; $display("FAIL alu_next_req_cycle5: rf_wen=%b pc=%h ireq=%b addr=%h want 0 80000004 1 80000004",
                        rf_wen, pc, imem_req_valid, imem_req_addr);
    end
    // Taken jump: pc follows the EXU target.
    exu_nextpc = 64'h8000_0100;
    do_fetch(32'h0fc0_006f);
    tick();
    n_vec++;
    if (rf_wen !== 1'b1) begin
      n_err++; $display("FAIL jal_wb: rf_wen=%b want 1", rf_wen);
    end
    tick();
    n_vec++;
    if (pc !== 64'h8000_0100 || imem_req_addr !== 64'h8000_0100) begin
      n_err++; $display("FAIL jal_target: pc=%h addr=%h want 80000100", pc, imem_req_addr);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    exu_nextpc = 64'h8000_0104;
    // Ready held low; stray responses in IF_REQ must not load the IR.
    for (int i = 0; i < 4; i++) begin
      imem_req_ready  = (i == 3);
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hbad0_0000 + 32'(i);
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100 || inst !== 32'h0fc0_006f) bad++;
      tick();
    end
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'hbadd_cafe;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL bp_req_stable: %0d unstable cycles, want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      if (imem_req_valid !== 1'b0 || inst !== 32'h0fc0_006f) bad++;
      tick();
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL bp_wait_no_capture: %0d bad cycles, want 0", bad);
    end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00a0_0113;
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if (inst !== 32'h00a0_0113) begin
      n_err++; $display("FAIL bp_capture: inst=%h want 00a00113", inst);
    end
    tick();
    n_vec++;
    if (rf_wen !== 1'b1) begin
      n_err++; $display("FAIL bp_wb: rf_wen=%b want 1", rf_wen);
    end
    tick();
    n_vec++;
    if (pc !== 64'h8000_0104 || imem_req_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_next: pc=%h ireq=%b want 80000104 1", pc, imem_req_valid);
    end
  endtask

  task automatic test_load_store();
    // Load: IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB.
    dec_is_load = 1'b1; exu_nextpc = 64'h8000_0108;
    do_fetch(32'h0000_b183);
    n_vec++;
    if (dmem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL ld_exec: dreq=%b want 0", dmem_req_valid);
    end
    tick();
    n_vec++;
    if (dmem_req_valid !== 1'b1 || dmem_req_wen !== 1'b0) begin
      n_err++; $display("FAIL ld_req: dreq=%b wen=%b want 1 0", dmem_req_valid, dmem_req_wen);
    end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1;
    tick();
    dmem_resp_valid = 1'b0;
    n_vec++;
    if (rf_wen !== 1'b1 || pc !== 64'h8000_0104) begin
      n_err++; $display("FAIL ld_wb_cycle6: rf_wen=%b pc=%h want 1 80000104", rf_wen, pc);
    end
    tick();
    n_vec++;
    if (pc !== 64'h8000_0108 || imem_req_valid !== 1'b1 || rf_wen !== 1'b0) begin
      n_err++; $display("FAIL ld_next: pc=%h ireq=%b rf_wen=%b want 80000108 1 0", pc, imem_req_valid, rf_wen);
    end
    // Store, with a response arriving together with ready (must be ignored).
    dec_is_load = 1'b0; dec_is_store = 1'b1; exu_nextpc = 64'h8000_0110;
    do_fetch(32'h0030_b423);
    tick();
    n_vec++;
    if (dmem_req_valid !== 1'b1 || dmem_req_wen !== 1'b1) begin
      n_err++; $display("FAIL sd_req: dreq=%b wen=%b want 1 1", dmem_req_valid, dmem_req_wen);
    end
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b1;
    tick();
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    tick();
    n_vec++;
    if (dmem_req_valid !== 1'b0 || rf_wen !== 1'b0 || pc !== 64'h8000_0108) begin
      n_err++; $display("FAIL sd_still_waiting: dreq=%b rf_wen=%b pc=%h want 0 0 80000108",
                        dmem_req_valid, rf_wen, pc);
    end
    dmem_resp_valid = 1'b1;
    tick();
    dmem_resp_valid = 1'b0;
    n_vec++;
    if (rf_wen !== 1'b0 || pc !== 64'h8000_0108) begin
      n_err++; $display("FAIL sd_wb_no_wen: rf_wen=%b pc=%h want 0 80000108", rf_wen, pc);
    end
    tick();
    dec_is_store = 1'b0;
    n_vec++;
    if (pc !== 64'h8000_0110 || imem_req_valid !== 1'b1 || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL sd_next: pc=%h ireq=%b tmo=%b want 80000110 1 0", pc, imem_req_valid, timeout_err);
    end
  endtask

  task automatic test_ebreak();
    int bad = 0;
    dec_is_ebreak = 1'b1; exu_nextpc = 64'hdead_beef;
    do_fetch(32'h0010_0073);
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL ebreak_exec: halted=%b want 0", halted);
    end
    tick();
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL ebreak_halt: halted=%b want 1", halted);
    end
    for (int i = 0; i < 100; i++) begin
      imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
      imem_resp_valid = i[0]; dmem_resp_valid = ~i[0];
      if (imem_req_valid !== 1'b0 || dmem_req_valid !== 1'b0 || rf_wen !== 1'b0 ||
          pc !== 64'h8000_0110 || halted !== 1'b1) bad++;
      tick();
    end
    idle_inputs();
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL ebreak_frozen: %0d active cycles in 100, want 0", bad);
    end
  endtask

  task automatic test_timeout();
    int n = 1;
    int bad = 0;
    apply_reset();
    dec_is_load = 1'b1; exu_nextpc = 64'h8000_0008;
    do_fetch(32'h0000_b183);
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    while (timeout_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_vec++;
    if (timeout_err !== 1'b1 || n != 15) begin
      n_err++; $display("FAIL timeout_latency: tmo=%b after %0d cycles, want 1 after 15", timeout_err, n);
    end
    for (int i = 0; i < 20; i++) begin
      dmem_resp_valid = 1'b1; imem_req_ready = 1'b1;
      if (imem_req_valid !== 1'b0 || dmem_req_valid !== 1'b0 || rf_wen !== 1'b0 ||
          pc !== RST_PC || timeout_err !== 1'b1) bad++;
      tick();
    end
    idle_inputs();
    n_vec++;
    if (bad != 0 || halted !== 1'b0) begin
      n_err++; $display("FAIL timeout_frozen: %0d active cycles halted=%b, want 0 0", bad, halted);
    end
  endtask

`ifdef CTRL_PERF_EN
  task automatic test_perf();
    apply_reset();
    n_vec++;
    if (perf_cycles !== 64'd0 || perf_retired !== 64'd0) begin
      n_err++; $display("FAIL perf_reset: cycles=%0d retired=%0d want 0 0", perf_cycles, perf_retired);
    end
    for (int i = 0; i < 10; i++) begin
      run_alu(NOP, RST_PC + 64'(4 * (i + 1)));
    end
    dec_is_ebreak = 1'b1;
    do_fetch(32'h0010_0073);
    tick();
    repeat (5) tick();
    n_vec++;
    if (perf_retired !== 64'd11 || perf_cycles !== 64'd43) begin
      n_err++; $display("FAIL perf_counts: retired=%0d cycles=%0d want 11 43", perf_retired, perf_cycles);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_stream();
    test_backpressure();
    test_load_store();
    test_ebreak();
    test_timeout();
`ifdef CTRL_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
